// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite encodings and the SRAM responder state set.
package ahb_sram_slave_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RD_ACC,
    ST_RD_CAP,
    ST_RD_OUT,
    ST_WR_DO,
    ST_ERR1,
    ST_ERR2
  } state_t;

endpackage

// File: rtl/ahb_be_decode.sv
// Maps an AHB transfer size and low address bits to 32-bit lane enables,
// flagging unsupported sizes and misaligned accesses.
module ahb_be_decode
  import ahb_sram_slave_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] be,
  output logic       err
);

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    be  = 4'b0000;
    err = 1'b0;
    case (hsize)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        be  = addr_lo[1] ? 4'b1100 : 4'b0011;
        err = addr_lo[0];
      end
      HSIZE_WORD: begin
        be  = 4'b1111;
        err = |addr_lo;
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder in front of a single-port synchronous SRAM with
// 1-cycle read latency, optional wait states and a two-cycle ERROR response.
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 18,
  parameter logic [31:0] WINDOW_MASK = 32'hfff0_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hsel,
  input  logic [31:0]           haddr,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hsize,
  input  logic                  hwrite,
  input  logic [31:0]           hwdata,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic                  hmastlock,
  input  logic                  hready,
  output logic [31:0]           hrdata,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [3:0]            sram_be,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata
);

  // Compared in 64 bits so large ADDR_WIDTH values cannot overflow the bound.
  localparam logic [63:0] CAPACITY  = 64'd4 << ADDR_WIDTH;
  localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_t                state_q, state_d, accept_state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [3:0]            be_q;
  logic [2:0]            wait_q;
  logic [31:0]           offset;
  logic [3:0]            be_dec;
  logic                  size_err, range_err, accept, take;
  logic                  unused_ok;

  assign offset    = haddr & ~WINDOW_MASK;
  assign range_err = {32'd0, offset} >= CAPACITY;
  assign accept    = hsel & hready & htrans[1];
  assign unused_ok = ^{htrans[0], hburst, hprot, hmastlock};

  ahb_be_decode u_be_decode (
    .hsize   (hsize),
    .addr_lo (haddr[1:0]),
    .be      (be_dec),
    .err     (size_err)
  );

  always_comb begin
    if (size_err || range_err) accept_state = ST_ERR1;
    else if (WAIT_STATES > 0)  accept_state = ST_WAIT;
    else if (hwrite)           accept_state = ST_WR_DO;
    else                       accept_state = ST_RD_ACC;
  end

  always_comb begin
    state_d   = state_q;
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    sram_ce   = 1'b0;
    sram_we   = 1'b0;
    sram_be   = 4'b0000;
    unique case (state_q)
      ST_IDLE, ST_RD_OUT: ;
      ST_WAIT: begin
        hreadyout = 1'b0;
        if (wait_q == 3'd0) state_d = write_q ? ST_WR_DO : ST_RD_ACC;
      end
      ST_RD_ACC: begin
        hreadyout = 1'b0;
        sram_ce   = 1'b1;
        state_d   = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        hreadyout = 1'b0;
        state_d   = ST_RD_OUT;
      end
      ST_WR_DO: begin
        sram_ce = 1'b1;
        sram_we = 1'b1;
        sram_be = be_q;
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      ST_ERR2: hresp = HRESP_ERROR;
    endcase
    // Any state that ends a data phase can take the next address phase directly.
    if (hreadyout) state_d = accept ? accept_state : ST_IDLE;
  end

  assign take       = accept & hreadyout;
  assign sram_addr  = addr_q;
  assign sram_wdata = hwdata;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      be_q    <= 4'b0000;
      wait_q  <= 3'd0;
      hrdata  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (take) begin
        addr_q  <= offset[ADDR_WIDTH+1:2];
        write_q <= hwrite;
        be_q    <= be_dec;
        wait_q  <= WAIT_LOAD;
      end else if (state_q == ST_WAIT && wait_q != 3'd0) begin
        wait_q <= wait_q - 3'd1;
      end
      if (state_q == ST_RD_CAP) hrdata <= sram_rdata;
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Two responders on one bus (no wait states / two wait states with a wider window),
// driven by a pipelining initiator and checked against a byte-level reference memory.
module tb_ahb_sram_slave;
  import ahb_sram_slave_pkg::*;

  localparam int          AW    = 18;
  localparam int          WS0   = 0;
  localparam int          WS1   = 2;
  localparam logic [31:0] MASK0 = 32'hfff0_0000;
  localparam logic [31:0] MASK1 = 32'hffe0_0000;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [1:0]           hsel;
  logic [31:0]          haddr, hwdata;
  logic [1:0]           htrans;
  logic [2:0]           hsize;
  logic                 hwrite, hready;
  logic [2:0]           hburst = 3'b000;
  logic [3:0]           hprot = 4'b0011;
  logic                 hmastlock = 1'b0;
  logic [1:0]           hreadyout, hresp, sram_ce, sram_we;
  logic [1:0][31:0]     hrdata, sram_wdata, sram_rdata;
  logic [1:0][3:0]      sram_be;
  logic [1:0][AW-1:0]   sram_addr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ahb_sram_slave #(.ADDR_WIDTH(AW), .WINDOW_MASK(MASK0), .WAIT_STATES(WS0)) dut0 (
    .clk(clk), .rst_n(rst_n), .hsel(hsel[0]), .haddr(haddr), .htrans(htrans), .hsize(hsize),
    .hwrite(hwrite), .hwdata(hwdata), .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock),
    .hready(hready), .hrdata(hrdata[0]), .hreadyout(hreadyout[0]), .hresp(hresp[0]),
    .sram_ce(sram_ce[0]), .sram_we(sram_we[0]), .sram_be(sram_be[0]), .sram_addr(sram_addr[0]),
    .sram_wdata(sram_wdata[0]), .sram_rdata(sram_rdata[0]));

  ahb_sram_slave #(.ADDR_WIDTH(AW), .WINDOW_MASK(MASK1), .WAIT_STATES(WS1)) dut1 (
    .clk(clk), .rst_n(rst_n), .hsel(hsel[1]), .haddr(haddr), .htrans(htrans), .hsize(hsize),
    .hwrite(hwrite), .hwdata(hwdata), .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock),
    .hready(hready), .hrdata(hrdata[1]), .hreadyout(hreadyout[1]), .hresp(hresp[1]),
    .sram_ce(sram_ce[1]), .sram_we(sram_we[1]), .sram_be(sram_be[1]), .sram_addr(sram_addr[1]),
    .sram_wdata(sram_wdata[1]), .sram_rdata(sram_rdata[1]));

  // Synchronous SRAM behind each responder; also counts every access strobe.
  for (genvar g = 0; g < 2; g++) begin : gen_sram
    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] rdata_q = 32'h0;
    int          n_strobe = 0;
    initial for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    always @(posedge clk) begin
      if (sram_ce[g]) begin
        n_strobe <= n_strobe + 1;
        if (sram_we[g]) begin
          for (int b = 0; b < 4; b++)
            if (sram_be[g][b]) mem[sram_addr[g]][8*b +: 8] <= sram_wdata[g][8*b +: 8];
        end else begin
          rdata_q <= mem[sram_addr[g]];
        end
      end
    end
    assign sram_rdata[g] = rdata_q;
  end

  typedef struct {
    int          idx;
    int          slv;
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_strobes;
    logic [3:0]  exp_be;
    logic [31:0] exp_word;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
  } xfer_t;

  xfer_t            q[$];
  logic [7:0]       ref_mem [longint];
  int               exp_total [2] = '{0, 0};
  int               next_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  function automatic logic [31:0] mask_of(input int s);
    return (s == 0) ? MASK0 : MASK1;
  endfunction

  function automatic logic [31:0] word_of(input int s, input logic [31:0] a);
    return ((a & ~mask_of(s)) >> 2) & ((32'd1 << AW) - 1);
  endfunction

  // Reference model: decides the response from the transfer rules and keeps memory as bytes.
  function automatic xfer_t predict(input xfer_t x);
    xfer_t       r = x;
    logic [31:0] off = x.addr & ~mask_of(x.slv);
    longint      base = (longint'(x.slv) << 32) | longint'(off & ~32'd3);
    int          nbytes;
    r.exp_be = 4'b0000; r.exp_rdata = 32'h0; r.chk_rdata = 1'b0;
    r.exp_word = word_of(x.slv, x.addr);
    if (!(x.sel && x.trans[1])) begin
      r.exp_err = 1'b0; r.exp_lat = 1; r.exp_strobes = 0;
      return r;
    end
    r.exp_err = (x.size > 3'd2) || ((x.addr % (32'd1 << x.size)) != 0) || (off >= (32'd4 << AW));
    if (r.exp_err) begin
      r.exp_lat = 2; r.exp_strobes = 0;
      return r;
    end
    r.exp_lat = (x.wr ? 1 : 3) + ((x.slv == 0) ? WS0 : WS1);
    r.exp_strobes = 1;
    exp_total[x.slv]++;
    nbytes = 1 << x.size;
    for (int i = 0; i < nbytes; i++) r.exp_be[int'(off % 4) + i] = 1'b1;
    for (int lane = 0; lane < 4; lane++) begin
      if (x.wr && r.exp_be[lane]) ref_mem[base + lane] = x.wdata[8*lane +: 8];
      r.exp_rdata[8*lane +: 8] = ref_mem.exists(base + lane) ? ref_mem[base + lane] : 8'h00;
    end
    r.chk_rdata = !x.wr;
    return r;
  endfunction

  function automatic xfer_t mk(input int slv, input logic sel, input logic [1:0] trans,
                               input logic wr, input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata);
    xfer_t x;
    x.idx = next_idx; next_idx++;
    x.slv = slv; x.sel = sel; x.trans = trans; x.wr = wr; x.size = size;
    x.addr = addr; x.wdata = wdata;
    x.exp_err = 1'b0; x.exp_lat = 0; x.exp_strobes = 0; x.exp_be = 4'b0000;
    x.exp_word = word_of(slv, addr); x.chk_rdata = 1'b0; x.exp_rdata = 32'h0;
    return x;
  endfunction

  function automatic xfer_t dir(input int slv, input logic sel, input logic [1:0] trans,
                                input logic wr, input logic [2:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic err, input int lat,
                                input logic [3:0] be, input logic [31:0] rdata);
    xfer_t x = mk(slv, sel, trans, wr, size, addr, wdata);
    x.exp_err     = err;
    x.exp_lat     = lat;
    x.exp_strobes = (sel && trans[1] && !err) ? 1 : 0;
    x.exp_be      = be;
    x.chk_rdata   = !wr && (x.exp_strobes == 1);
    x.exp_rdata   = rdata;
    return x;
  endfunction

  // Pipelined initiator: address phase of the next transfer overlaps the current data phase.
  task automatic run_queue();
    xfer_t       ap, dp;
    logic        ap_v = 1'b0, dp_v = 1'b0, hr;
    int          cyc = 0, strobes = 0;
    logic [3:0]  seen_be = 4'b0000;
    logic [31:0] seen_addr = 32'h0;
    string       tag;
    if (q.size() > 0) begin ap = q.pop_front(); ap_v = 1'b1; end
    while (ap_v || dp_v) begin
      @(negedge clk);
      hsel = 2'b00; htrans = HTRANS_IDLE; haddr = 32'h0; hwrite = 1'b0; hsize = HSIZE_BYTE;
      if (ap_v) begin
        hsel[ap.slv] = ap.sel; htrans = ap.trans; haddr = ap.addr; hwrite = ap.wr; hsize = ap.size;
      end
      hwdata = dp_v ? dp.wdata : 32'h0;
      hr     = dp_v ? hreadyout[dp.slv] : 1'b1;
      hready = hr;
      if (dp_v) begin
        cyc++;
        tag = $sformatf("#%0d", dp.idx);
        if (sram_ce[dp.slv]) begin
          strobes++;
          seen_be   = sram_be[dp.slv];
          seen_addr = 32'(sram_addr[dp.slv]);
        end
        check({"hresp", tag}, 32'(hresp[dp.slv]), 32'(dp.exp_err));
        if (hr) begin
          check({"latency", tag}, cyc, dp.exp_lat);
          check({"strobes", tag}, strobes, dp.exp_strobes);
          if (dp.exp_strobes == 1) check({"sram_addr", tag}, seen_addr, dp.exp_word);
          if (dp.exp_strobes == 1 && dp.wr) check({"sram_be", tag}, 32'(seen_be), 32'(dp.exp_be));
          if (dp.chk_rdata) check({"hrdata", tag}, hrdata[dp.slv], dp.exp_rdata);
        end else if (cyc > 16) begin
          check({"timeout", tag}, 32'(hr), 32'd1);
          finish_sim();
        end
      end
      if (hr) begin
        dp = ap; dp_v = ap_v; cyc = 0; strobes = 0;
        if (q.size() > 0) begin ap = q.pop_front(); ap_v = 1'b1; end
        else ap_v = 1'b0;
      end
    end
  endtask

  initial begin
    xfer_t tbl[$];
    xfer_t x;
    int    sz, slv;
    logic [31:0] off, word;

    rst_n = 1'b0; hsel = 2'b00; haddr = 32'h0; htrans = HTRANS_IDLE; hsize = HSIZE_BYTE;
    hwrite = 1'b0; hwdata = 32'h0; hready = 1'b1;
    #12;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("rst_hreadyout%0d", s), 32'(hreadyout[s]), 32'd1);
      check($sformatf("rst_hresp%0d", s), 32'(hresp[s]), 32'd0);
      check($sformatf("rst_hrdata%0d", s), hrdata[s], 32'h0);
      check($sformatf("rst_ce_we_be%0d", s), {26'd0, sram_ce[s], sram_we[s], sram_be[s]}, 32'h0);
      check($sformatf("rst_sram_addr%0d", s), 32'(sram_addr[s]), 32'h0);
    end
    @(negedge clk); rst_n = 1'b1;

    // slv sel trans wr size addr wdata | err lat be rdata
    tbl.push_back(dir(0, 1, HTRANS_NONSEQ, 1, 2, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1, 4'b1111, 32'h0));
    tbl.push_back(dir(0, 1, HTRANS_NONSEQ, 0, 2, 32'h0000_0010, 32'h0,         0, 3, 4'b0000, 32'hDEAD_BEEF));
    tbl.push_back(dir(0, 1, HTRANS_NONSEQ, 1, 0, 32'h0000_0013, 32'hA500_0000, 0, 1, 4'b1000, 32'h0));
    tbl.push_back(dir(0, 1, HTRANS_NONSEQ, 0, 2, 32'h0000_0010, 32'h0,         0, 3, 4'b0000, 32'hA5AD_BEEF));
    tbl.push_back(dir(0, 1, HTRANS_NONSEQ, 1, 2, 32'h0000_0002, 32'h1111_1111, 1, 2, 4'b0000, 32'h0));
    tbl.push_back(dir(0, 1, HTRANS_NONSEQ, 0, 3, 32'h0000_0000, 32'h0,         1, 2, 4'b0000, 32'h0));
    tbl.push_back(dir(0, 1, HTRANS_NONSEQ, 1, 1, 32'h0000_0011, 32'h2222_2222, 1, 2, 4'b0000, 32'h0));
    tbl.push_back(dir(1, 1, HTRANS_NONSEQ, 1, 2, 32'h0000_0100, 32'h1234_5678, 0, 3, 4'b1111, 32'h0));
    tbl.push_back(dir(1, 1, HTRANS_SEQ,    0, 2, 32'h0000_0100, 32'h0,         0, 5, 4'b0000, 32'h1234_5678));
    tbl.push_back(dir(1, 1, HTRANS_NONSEQ, 0, 2, 32'h0010_0000, 32'h0,         1, 2, 4'b0000, 32'h0));
    tbl.push_back(dir(1, 1, HTRANS_NONSEQ, 0, 2, 32'h000F_FFFC, 32'h0,         0, 5, 4'b0000, 32'h0));
    tbl.push_back(dir(0, 1, HTRANS_NONSEQ, 0, 2, 32'h1fc0_0010, 32'h0,         0, 3, 4'b0000, 32'hA5AD_BEEF));
    tbl.push_back(dir(0, 0, HTRANS_NONSEQ, 1, 2, 32'h0000_0010, 32'hFFFF_FFFF, 0, 1, 4'b0000, 32'h0));
    tbl.push_back(dir(0, 1, HTRANS_BUSY,   1, 2, 32'h0000_0010, 32'hFFFF_FFFF, 0, 1, 4'b0000, 32'h0));
    tbl.push_back(dir(0, 1, HTRANS_NONSEQ, 1, 1, 32'h0000_0012, 32'h7766_0000, 0, 1, 4'b1100, 32'h0));
    tbl.push_back(dir(0, 1, HTRANS_NONSEQ, 0, 2, 32'h0000_0010, 32'h0,         0, 3, 4'b0000, 32'h7766_BEEF));
    for (int i = 0; i < tbl.size(); i++) begin
      x = predict(tbl[i]);
      q.push_back(tbl[i]);
    end
    run_queue();

    // Reset asserted while a read sits in its capture cycle.
    @(negedge clk);
    hsel = 2'b01; htrans = HTRANS_NONSEQ; haddr = 32'h0000_0010; hwrite = 1'b0; hsize = HSIZE_WORD;
    hready = 1'b1;
    @(negedge clk);
    hsel = 2'b00; htrans = HTRANS_IDLE; hready = hreadyout[0];
    check("abort_rd_acc_ce", 32'(sram_ce[0]), 32'd1);
    check("abort_hrdata_hold", hrdata[0], 32'h7766_BEEF);
    exp_total[0]++;
    @(negedge clk);
    check("abort_rd_cap_ready", 32'(hreadyout[0]), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("abort_hreadyout", 32'(hreadyout[0]), 32'd1);
    check("abort_hrdata", hrdata[0], 32'h0);
    check("abort_sram_ce", 32'(sram_ce[0]), 32'd0);
    @(negedge clk); rst_n = 1'b1; hready = 1'b1;
    q.push_back(predict(mk(0, 1, HTRANS_NONSEQ, 0, 2, 32'h0000_0010, 32'h0)));
    run_queue();

    // Randomized traffic across both responders.
    for (int n = 0; n < 300; n++) begin
      slv  = $urandom_range(0, 1);
      sz   = ($urandom_range(0, 7) < 7) ? $urandom_range(0, 2) : $urandom_range(3, 7);
      word = ($urandom_range(0, 4) == 0) ? ((32'd1 << AW) - $urandom_range(1, 4)) : $urandom_range(0, 15);
      off  = (word << 2) | $urandom_range(0, 3);
      if (sz <= 2 && $urandom_range(0, 3) != 0) off = off & ~((32'd1 << sz) - 1);
      if (slv == 1 && $urandom_range(0, 7) == 0) off = off | 32'h0010_0000;
      x = mk(slv, $urandom_range(0, 9) != 0,
             ($urandom_range(0, 9) == 0) ? HTRANS_IDLE :
             ($urandom_range(0, 9) == 0) ? HTRANS_BUSY :
             ($urandom_range(0, 1) == 0) ? HTRANS_NONSEQ : HTRANS_SEQ,
             $urandom_range(0, 1) == 1, 3'(sz), ($urandom() & mask_of(slv)) | off, $urandom());
      q.push_back(predict(x));
    end
    run_queue();

    @(negedge clk);
    check("strobe_total0", gen_sram[0].n_strobe, exp_total[0]);
    check("strobe_total1", gen_sram[1].n_strobe, exp_total[1]);
    finish_sim();
  end

  initial begin
    #1_000_000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_sim();
  end

endmodule
